// File: rtl/spike_generator_if.sv
// Program and tag-output channels of the spike generator bank.
// DUT side is the slave modport; the driver/consumer uses master.
interface spike_generator_if #(
  parameter int Ngens   = 8,
  parameter int Nperiod = 16,
  parameter int Ntag    = 11,
  parameter int Nct     = 9
);
  logic [Ngens-1:0]   prog_gen_idx;
  logic [Nperiod-1:0] prog_period;
  logic [Nperiod-1:0] prog_ticks;
  logic [Ntag-1:0]    prog_tag;
  logic               prog_v;
  logic               prog_a;
  logic [Ntag-1:0]    out_tag;
  logic [Nct-1:0]     out_ct;
  logic               out_v;
  logic               out_a;

  modport slave (
    input  prog_gen_idx, prog_period,
    input  prog_ticks, prog_tag, prog_v,
    output prog_a,
    output out_tag, out_ct, out_v,
    input  out_a
  );

  modport master (
    output prog_gen_idx, prog_period,
    output prog_ticks, prog_tag, prog_v,
    input  prog_a,
    input  out_tag, out_ct, out_v,
    output out_a
  );
endinterface

// File: rtl/spike_generator.sv
// Bank of periodic spike sources swept once per time unit;
// each expiring generator emits its tag with count 1.
module spike_generator #(
  parameter int Ngens   = 8,
  parameter int Nperiod = 16,
  parameter int Ntag    = 11,
  parameter int Nct     = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                time_unit,
  input  logic [Ngens-1:0]    gens_used,
  input  logic [2**Ngens-1:0] gens_en,
  spike_generator_if.slave    bus,
  output logic                overrun
);
  localparam int W = 2*Nperiod + Ntag;

  typedef enum logic [2:0] {
    IDLE, RD, EVAL, EMIT, NEXT
  } state_t;

  state_t r_state, w_next;

  logic [W-1:0]       r_mem [2**Ngens];
  logic [W-1:0]       r_rdata;
  logic [Ngens-1:0]   r_idx;
  logic               r_pending;
  logic               r_overrun;
  logic               r_out_v;
  logic [Ntag-1:0]    r_out_tag;

  logic               w_we;
  logic [Ngens-1:0]   w_waddr;
  logic [W-1:0]       w_wdata;
  logic               w_fire;
  logic               w_start;
  logic               w_prog_a;
  logic [Nperiod-1:0] w_period;
  logic [Nperiod-1:0] w_ticks;
  logic [Ntag-1:0]    w_tag;

  assign w_period = r_rdata[W-1 -: Nperiod];
  assign w_ticks  = r_rdata[Ntag+Nperiod-1 -: Nperiod];
  assign w_tag    = r_rdata[Ntag-1:0];

  assign w_prog_a = bus.prog_v && (r_state == IDLE);
  assign w_start  = (r_state == IDLE) && r_pending
                    && !bus.prog_v;

  assign bus.prog_a  = w_prog_a;
  assign bus.out_v   = r_out_v;
  assign bus.out_tag = r_out_tag;
  assign bus.out_ct  = Nct'(1);
  assign overrun     = r_overrun;

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = r_idx;
    w_wdata = r_rdata;
    w_fire  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_prog_a) begin
          w_we    = 1'b1;
          w_waddr = bus.prog_gen_idx;
          w_wdata = {bus.prog_period,
                     bus.prog_ticks,
                     bus.prog_tag};
        end else if (r_pending) begin
          w_next = RD;
        end
      end
      RD: w_next = EVAL;
      EVAL: begin
        w_next = NEXT;
        if (gens_en[r_idx] && w_period != '0) begin
          w_we = 1'b1;
          // ticks of 0 or 1 both expire now; no wrap
          if (w_ticks <= Nperiod'(1)) begin
            w_wdata = {w_period, w_period, w_tag};
            w_fire  = 1'b1;
            w_next  = EMIT;
          end else begin
            w_wdata = {w_period,
                       w_ticks - Nperiod'(1),
                       w_tag};
          end
        end
      end
      EMIT: if (bus.out_a) w_next = NEXT;
      NEXT: begin
        if (r_idx == gens_used) w_next = IDLE;
        else                    w_next = RD;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we && !reset) r_mem[w_waddr] <= w_wdata;
    r_rdata <= r_mem[r_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_out_v   <= 1'b0;
      r_out_tag <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE)
        r_idx <= '0;
      else if (r_state == NEXT && r_idx != gens_used)
        r_idx <= r_idx + Ngens'(1);
      if (time_unit && r_pending)
        r_overrun <= 1'b1;
      if (w_start)
        r_pending <= 1'b0;
      else if (time_unit)
        r_pending <= 1'b1;
      if (w_fire) begin
        r_out_v   <= 1'b1;
        r_out_tag <= w_tag;
      end else if (r_state == EMIT && bus.out_a) begin
        r_out_v <= 1'b0;
      end
    end
  end
endmodule
